// File: rtl/zint_prog_if.sv
// zint_prog_if: interrupt-generator bus; master drives strobes/Z80 pins/config, slave returns int_n, int_active, int_missed
interface zint_prog_if #(
  parameter int DLY_W = 16,
  parameter int LEN_W = 8
) ();
  logic             int_start;
  logic             zpos;
  logic             iorq_n;
  logic             m1_n;
  logic [DLY_W-1:0] cfg_delay;
  logic [LEN_W-1:0] cfg_len;
  logic             int_n;
  logic             int_active;
  logic             int_missed;
  modport master (
    output int_start, zpos, iorq_n, m1_n, cfg_delay, cfg_len,
    input  int_n, int_active, int_missed
  );
  modport slave (
    input  int_start, zpos, iorq_n, m1_n, cfg_delay, cfg_len,
    output int_n, int_active, int_missed
  );
endinterface

// File: rtl/zint_prog.sv
// zint_prog: programmable Z80 INT# generator (delay then hold low, counted in zpos strobes); ports fclk, rst_n (async low), bus (zint_prog_if.slave); ZINT_ACKCLR_EN enables early clear on IORQ#/M1# acknowledge
module zint_prog #(
  parameter int DLY_W  = 16,
  parameter int LEN_W  = 8,
  parameter int SYNC_N = 2
) (
  input logic        fclk,
  input logic        rst_n,
  zint_prog_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DELAY, ASSERT} state_t;
  state_t           state_q, state_d;
  logic [DLY_W-1:0] dcnt_q, dcnt_d;
  logic [LEN_W-1:0] lcnt_q, lcnt_d;
  logic             int_n_q, int_active_q, int_missed_q;
  logic [SYNC_N-1:0] iorq_q, m1_q;
  logic             ack_en, ack;
`ifdef ZINT_ACKCLR_EN
  assign ack_en = 1'b1;
`else
  assign ack_en = 1'b0;
`endif
  assign ack = ack_en & ~iorq_q[SYNC_N-1] & ~m1_q[SYNC_N-1];
  always_ff @(posedge fclk or negedge rst_n)
    if (!rst_n) begin
      iorq_q <= '1;
      m1_q   <= '1;
    end else begin
      iorq_q <= {iorq_q[SYNC_N-2:0], bus.iorq_n};
      m1_q   <= {m1_q[SYNC_N-2:0], bus.m1_n};
    end
  // Each state only counts zpos seen while it is current, so the strobe in a
  // transition cycle belongs to the state being left.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      IDLE:
        if (bus.int_start) begin
          dcnt_d  = bus.cfg_delay;
          lcnt_d  = bus.cfg_len;
          state_d = (bus.cfg_delay != '0) ? DELAY : ASSERT;
        end
      DELAY:
        if (bus.zpos) begin
          dcnt_d  = dcnt_q - 1'b1;
          state_d = (dcnt_q == DLY_W'(1)) ? ASSERT : DELAY;
        end
      ASSERT:
        if (ack) state_d = IDLE;
        else if (bus.zpos) begin
          // A loaded 0 wraps to all-ones here, giving 2**LEN_W strobes.
          lcnt_d  = lcnt_q - 1'b1;
          state_d = (lcnt_q == LEN_W'(1)) ? IDLE : ASSERT;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge fclk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      dcnt_q       <= '0;
      lcnt_q       <= '0;
      int_n_q      <= 1'b1;
      int_active_q <= 1'b0;
      int_missed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      lcnt_q       <= lcnt_d;
      int_n_q      <= state_d != ASSERT;
      int_active_q <= state_d != IDLE;
      int_missed_q <= bus.int_start & (state_q != IDLE);
    end
  assign bus.int_n      = int_n_q;
  assign bus.int_active = int_active_q;
  assign bus.int_missed = int_missed_q;
endmodule
